// File: rtl/hht_pkg.sv
// Shared types and default sizing for the column engine: the FSM state enum
// and the default parameter constants.
package hht_pkg;

    localparam int HHT_DATA_W = 32;
    localparam int HHT_ADDR_W = 32;
    localparam int HHT_VLEN   = 16;
    localparam int HHT_SHIFT  = 1;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD_V   = 3'd1,
        ST_LOAD_COL = 3'd2,
        ST_EMIT     = 3'd3,
        ST_DONE     = 3'd4
    } hht_state_e;

endpackage

// File: rtl/hht_mac.sv
// Signed multiply-accumulate with a 2*W wrapping accumulator. When clr and en
// are both high, the accumulator restarts from the current product.
module hht_mac #(
    parameter int W = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  en,
    input  logic signed [W-1:0]   a,
    input  logic signed [W-1:0]   b,
    output logic signed [2*W-1:0] acc
);

    logic signed [2*W-1:0] a_x;
    logic signed [2*W-1:0] b_x;
    logic signed [2*W-1:0] prod;

    assign a_x  = {{W{a[W-1]}}, a};
    assign b_x  = {{W{b[W-1]}}, b};
    assign prod = a_x * b_x;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (en) begin
            acc <= (clr ? '0 : acc) + prod;
        end else if (clr) begin
            acc <= '0;
        end
    end

endmodule

// File: rtl/hht_col_engine.sv
// Householder-style column update: loads v once, then for each column computes
// dot = col.v and streams col[k] - ((dot*v[k]) >>> SHIFT) over a valid/ready port.
module hht_col_engine
    import hht_pkg::*;
#(
    parameter int DATA_W = HHT_DATA_W,
    parameter int ADDR_W = HHT_ADDR_W,
    parameter int VLEN   = HHT_VLEN,
    parameter int SHIFT  = HHT_SHIFT
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] v_base,
    input  logic [ADDR_W-1:0] col_base,
    input  logic [15:0]       num_cols,
    output logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] dataIn1,
    output logic [ADDR_W-1:0] addr2,
    input  logic [DATA_W-1:0] dataIn2,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [15:0]       out_col,
    output logic [5:0]        out_idx,
    output logic              busy,
    output logic              done,
    output hht_state_e        dbg_state
);

    // Result port handshake: a beat transfers on a rising Clk edge where
    // out_valid and out_ready are both high; while out_valid is high and
    // out_ready low, out_data/out_idx/out_col hold their values.

    localparam int         IW     = (VLEN > 1) ? $clog2(VLEN) : 1;
    localparam logic [5:0] K_LAST = 6'(VLEN - 1);

    hht_state_e               state;
    logic [5:0]               k;
    logic [IW-1:0]            ki;
    logic [15:0]              c;
    logic [15:0]              num_cols_q;
    logic [ADDR_W-1:0]        col_base_q;
    logic signed [DATA_W-1:0] v_buf   [VLEN];
    logic signed [DATA_W-1:0] col_buf [VLEN];

    logic                       mac_en;
    logic                       mac_clr;
    logic signed [2*DATA_W-1:0] dot;

    logic signed [DATA_W-1:0]   v_k;
    logic signed [DATA_W-1:0]   c_k;
    logic signed [2*DATA_W-1:0] v_ext;
    logic signed [2*DATA_W-1:0] scaled;
    logic signed [2*DATA_W-1:0] shifted;
    logic [DATA_W-1:0]          result;
    logic                       emit;
    logic                       k_last;

    assign ki     = k[IW-1:0];
    assign k_last = (k == K_LAST);
    assign emit   = (state == ST_EMIT);

    // The first fetch of a column restarts the accumulator, so dot never
    // carries over from the previous column.
    assign mac_en  = (state == ST_LOAD_COL);
    assign mac_clr = mac_en && (k == 6'd0);

    hht_mac #(.W(DATA_W)) u_mac (
        .clk   (Clk),
        .rst_n (Rst),
        .clr   (mac_clr),
        .en    (mac_en),
        .a     ($signed(dataIn1)),
        .b     (v_buf[ki]),
        .acc   (dot)
    );

    assign v_k     = v_buf[ki];
    assign c_k     = col_buf[ki];
    assign v_ext   = {{DATA_W{v_k[DATA_W-1]}}, v_k};
    assign scaled  = dot * v_ext;
    assign shifted = scaled >>> SHIFT;
    assign result  = c_k - shifted[DATA_W-1:0];

    // Every output term comes from registers that only move on a transfer,
    // which keeps the beat stable during a stall.
    assign out_valid = emit;
    assign out_data  = emit ? result : '0;
    assign out_idx   = emit ? k : 6'd0;
    assign out_col   = emit ? c : 16'd0;
    assign dbg_state = state;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state      <= ST_IDLE;
            addr1      <= '0;
            addr2      <= '0;
            k          <= '0;
            c          <= '0;
            num_cols_q <= '0;
            col_base_q <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            for (int i = 0; i < VLEN; i++) begin
                v_buf[i]   <= '0;
                col_buf[i] <= '0;
            end
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        num_cols_q <= num_cols;
                        col_base_q <= col_base;
                        c          <= '0;
                        k          <= '0;
                        if (num_cols == 16'd0) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= ST_LOAD_V;
                            addr2 <= v_base;
                            busy  <= 1'b1;
                        end
                    end
                end
                ST_LOAD_V: begin
                    v_buf[ki] <= dataIn2;
                    if (k_last) begin
                        k     <= '0;
                        state <= ST_LOAD_COL;
                        addr1 <= col_base_q;
                    end else begin
                        k     <= k + 6'd1;
                        addr2 <= addr2 + 1'b1;
                    end
                end
                ST_LOAD_COL: begin
                    col_buf[ki] <= dataIn1;
                    if (k_last) begin
                        k     <= '0;
                        state <= ST_EMIT;
                    end else begin
                        k     <= k + 6'd1;
                        addr1 <= addr1 + 1'b1;
                    end
                end
                ST_EMIT: begin
                    if (out_ready) begin
                        if (k_last) begin
                            k <= '0;
                            if (c == num_cols_q - 16'd1) begin
                                state <= ST_DONE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end else begin
                                // Columns are contiguous, so the next one starts
                                // right after the last word fetched.
                                c     <= c + 16'd1;
                                state <= ST_LOAD_COL;
                                addr1 <= addr1 + 1'b1;
                            end
                        end else begin
                            k <= k + 6'd1;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hht_col_engine.sv
// Self-checking bench for hht_col_engine: directed scenarios plus random jobs,
// scored against a plain-arithmetic reference model.
module tb_hht_col_engine;
    import hht_pkg::*;

    localparam int DW = 16;
    localparam int AW = 16;
    localparam int VL = 4;
    localparam int SH = 1;
    localparam int EW = 16 + 6 + DW;
    localparam int TMO = 3000;

    logic          Clk;
    logic          Rst;
    logic          start;
    logic [AW-1:0] v_base;
    logic [AW-1:0] col_base;
    logic [15:0]   num_cols;
    logic [AW-1:0] addr1;
    logic [DW-1:0] dataIn1;
    logic [AW-1:0] addr2;
    logic [DW-1:0] dataIn2;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [15:0]   out_col;
    logic [5:0]    out_idx;
    logic          busy;
    logic          done;
    hht_state_e    dbg_state;

    logic [DW-1:0] mem1 [256];
    logic [DW-1:0] mem2 [256];

    assign dataIn1 = mem1[addr1[7:0]];
    assign dataIn2 = mem2[addr2[7:0]];

    hht_col_engine #(.DATA_W(DW), .ADDR_W(AW), .VLEN(VL), .SHIFT(SH)) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .start     (start),
        .v_base    (v_base),
        .col_base  (col_base),
        .num_cols  (num_cols),
        .addr1     (addr1),
        .dataIn1   (dataIn1),
        .addr2     (addr2),
        .dataIn2   (dataIn2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_col   (out_col),
        .out_idx   (out_idx),
        .busy      (busy),
        .done      (done),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    // ---------------- checking ----------------
    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- scoreboard ----------------
    logic [EW-1:0] exp_q[$];
    int            beats = 0;
    int            done_cnt = 0;
    int            done_cyc = 0;
    int            first_valid_cyc = -1;
    bit            valid_seen = 0;
    bit            stalled = 0;
    logic [EW-1:0] held;

    always @(negedge Clk) begin
        if (!Rst) begin
            stalled = 0;
        end else begin
            if (stalled)
                check("hold", {out_valid, out_col, out_idx, out_data}, {1'b1, held});
            if (out_valid) begin
                valid_seen = 1;
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
            end
            if (out_valid && out_ready) begin
                beats++;
                if (exp_q.size() == 0) check("extra_beat", 1, 0);
                else check("beat", {out_col, out_idx, out_data}, exp_q.pop_front());
                stalled = 0;
            end else if (out_valid) begin
                stalled = 1;
                held    = {out_col, out_idx, out_data};
            end else begin
                stalled = 0;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    // ---------------- reference model ----------------
    // dot wraps to 32 bits, dot*v wraps to 32 bits, arithmetic shift, keep 16 bits.
    task automatic build_exp(input logic [15:0] vb, input logic [15:0] cb, input logic [15:0] nc);
        for (int col = 0; col < int'(nc); col++) begin
            longint dot = 0;
            int     d32;
            for (int k = 0; k < VL; k++)
                dot += longint'($signed(mem1[8'(int'(cb) + col*VL + k)])) *
                       longint'($signed(mem2[8'(int'(vb) + k)]));
            d32 = int'(dot);
            for (int k = 0; k < VL; k++) begin
                int            cv  = int'($signed(mem1[8'(int'(cb) + col*VL + k)]));
                int            vv  = int'($signed(mem2[8'(int'(vb) + k)]));
                int            p32 = int'(longint'(d32) * longint'(vv));
                int            sh  = p32 >>> SH;
                logic [DW-1:0] r   = DW'(cv - sh);
                exp_q.push_back({16'(col), 6'(k), r});
            end
        end
    endtask

    // ---------------- drivers ----------------
    function automatic logic ready_for(input int mode, input int t);
        case (mode)
            0:       return 1'b1;
            1:       return 1'($urandom_range(0, 1));
            2:       return ((t % 4) == 0) || ((t % 4) == 3);
            default: return 1'b0;
        endcase
    endfunction

    task automatic fill_random();
        for (int i = 0; i < 256; i++) begin
            mem1[i] = DW'($urandom_range(0, 65535));
            mem2[i] = DW'($urandom_range(0, 65535));
        end
    endtask

    task automatic run_job(input logic [15:0] vb, input logic [15:0] cb, input logic [15:0] nc,
                           input int mode, input bit glitch);
        int            start_cyc;
        int            n0;
        int            t;
        logic [AW-1:0] a1_snap;
        logic [AW-1:0] a2_snap;
        build_exp(vb, cb, nc);
        beats = 0; first_valid_cyc = -1; valid_seen = 0; n0 = done_cnt;
        @(posedge Clk); #1;
        a1_snap = addr1; a2_snap = addr2;
        v_base = vb; col_base = cb; num_cols = nc; start = 1'b1;
        start_cyc = cyc;
        out_ready = ready_for(mode, 0);
        t = 0;
        while (done_cnt == n0 && t < TMO) begin
            @(posedge Clk); #1;
            t++;
            start = 1'b0;
            if (glitch && t == 2*VL - 2) begin
                start = 1'b1; v_base = vb + 16'd8; col_base = cb + 16'd8; num_cols = nc + 16'd1;
            end
            out_ready = ready_for(mode, t);
        end
        start = 1'b0;
        check("timeout", 64'(t < TMO), 1);
        check("drain", exp_q.size(), 0);
        check("beat_count", beats, int'(nc) * VL);
        if (nc == 16'd0) begin
            check("done_latency", done_cyc - start_cyc, 1);
            check("no_valid", valid_seen, 0);
            check("addr_hold", {addr1, addr2}, {a1_snap, a2_snap});
        end else if (mode == 0) begin
            check("emit_latency", first_valid_cyc - start_cyc, 2*VL + 1);
        end
        exp_q.delete();
        out_ready = 1'b1;
        @(posedge Clk); #1;
        check("idle_after", {busy, done, out_valid, 5'(dbg_state)}, {3'b000, 5'(ST_IDLE)});
    endtask

    task automatic check_reset_outputs(input string tag);
        check(tag, {out_valid, out_data, out_col, out_idx, busy, done, addr1, addr2},
              {1'b0, DW'(0), 16'd0, 6'd0, 1'b0, 1'b0, AW'(0), AW'(0)});
        check({tag, "_state"}, dbg_state, ST_IDLE);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        Rst = 1'b0; start = 1'b0; v_base = '0; col_base = '0; num_cols = '0; out_ready = 1'b1;
        fill_random();
        repeat (3) @(posedge Clk);
        #1;
        check_reset_outputs("reset");
        Rst = 1'b1;
        repeat (3) @(posedge Clk);
        #1;
        check("no_fetch_after_reset", {addr1, addr2, busy}, 33'd0);

        // single column, unit v, ready always high
        mem2[0] = 16'd1; mem2[1] = 16'd0; mem2[2] = 16'd0; mem2[3] = 16'd0;
        mem1[32] = 16'd4; mem1[33] = 16'd2; mem1[34] = 16'd3; mem1[35] = 16'd1;
        run_job(16'd0, 16'd32, 16'd1, 0, 1'b0);

        // zero columns
        run_job(16'd0, 16'd32, 16'd0, 0, 1'b0);

        // two columns, ready pattern 1,0,0,1
        run_job(16'd4, 16'd64, 16'd2, 2, 1'b0);

        // signed values
        mem2[8] = 16'hFFFF; mem2[9] = 16'd2; mem2[10] = 16'd0; mem2[11] = 16'd0;
        mem1[96] = 16'd3; mem1[97] = 16'hFFFB; mem1[98] = 16'd0; mem1[99] = 16'd0;
        run_job(16'd8, 16'd96, 16'd1, 0, 1'b0);

        // reset in the middle of a stalled emit
        begin
            int w = 0;
            build_exp(16'd12, 16'd128, 16'd2);
            @(posedge Clk); #1;
            v_base = 16'd12; col_base = 16'd128; num_cols = 16'd2; start = 1'b1; out_ready = 1'b0;
            @(posedge Clk); #1;
            start = 1'b0;
            while (!out_valid && w < TMO) begin
                @(posedge Clk); #1;
                w++;
            end
            check("reach_emit", out_valid, 1);
            #2 Rst = 1'b0;
            #1 check_reset_outputs("mid_reset");
            exp_q.delete();
            @(posedge Clk); #1;
            Rst = 1'b1; out_ready = 1'b1;
            repeat (2) @(posedge Clk);
            #1;
            check("quiet_after_reset", {addr1, addr2, busy}, 33'd0);
            run_job(16'd12, 16'd128, 16'd2, 0, 1'b0);
        end

        // restart attempt during LOAD_COL must be ignored
        run_job(16'd16, 16'd160, 16'd2, 1, 1'b1);

        // random jobs
        for (int j = 0; j < 6; j++) begin
            fill_random();
            run_job(16'($urandom_range(0, 40)), 16'($urandom_range(48, 200)),
                    16'($urandom_range(1, 3)), 1, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hht_col_engine.md
HHT_COL_ENGINE -- requirements
Module: hht_col_engine

Interface
REQ-001 SHALL have parameter DATA_W, default 32, data word width.
REQ-002 SHALL have parameter ADDR_W, default 32, memory address width.
REQ-003 SHALL have parameter VLEN, default 16, vector length and column length, range 2..64.
REQ-004 SHALL have parameter SHIFT, default 1, right-shift applied to each dot*v product.
REQ-005 SHALL have port Clk  in  1  the single clock; all state updates on its rising edge.
REQ-006 SHALL have port Rst  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have port start  in  1  one-cycle request to begin; sampled only in IDLE.
REQ-008 SHALL have port v_base  in  ADDR_W  base address of the v vector in memory port 2.
REQ-009 SHALL have port col_base  in  ADDR_W  base address of column 0 in memory port 1.
REQ-010 SHALL have port num_cols  in  16  number of columns to process.
REQ-011 SHALL have ports addr1 out ADDR_W and dataIn1 in DATA_W: column memory, combinational read, data valid in the same cycle as the address.
REQ-012 SHALL have ports addr2 out ADDR_W and dataIn2 in DATA_W: v memory, same timing as port 1.
REQ-013 SHALL have ports out_valid out 1, out_ready in 1, out_data out DATA_W: result stream.
REQ-014 SHALL have ports out_col out 16 and out_idx out 6: column and element index of out_data.
REQ-015 SHALL have ports busy out 1 (high outside IDLE/DONE) and done out 1 (one-cycle pulse at completion).

Function
REQ-016 FSM states SHALL be IDLE, LOAD_V, LOAD_COL, EMIT, DONE.
REQ-017 In IDLE, start=1 with num_cols>0 SHALL latch all inputs and enter LOAD_V; with num_cols=0 it SHALL enter DONE directly.
REQ-018 LOAD_V SHALL drive addr2=v_base+k for k=0..VLEN-1, one per cycle, storing dataIn2 in v_buf[k]; it lasts exactly VLEN cycles.
REQ-019 LOAD_COL SHALL drive addr1=col_base+c*VLEN+k for k=0..VLEN-1, one per cycle, storing col_buf[k] and accumulating dot+=dataIn1*v_buf[k]; dot cleared on entry; it lasts exactly VLEN cycles.
REQ-020 EMIT SHALL present out_data = col_buf[k] - ((dot*v_buf[k]) >>> SHIFT), out_idx=k, out_col=c, for k=0..VLEN-1.
REQ-021 A beat SHALL transfer when out_valid and out_ready are both high; k advances only on transfer.
REQ-022 While out_valid=1 and out_ready=0, out_data, out_idx and out_col SHALL remain stable.
REQ-023 After beat VLEN-1 transfers: if c<num_cols-1, SHALL increment c and enter LOAD_COL; else enter DONE.
REQ-024 DONE SHALL assert done for exactly one cycle, then return to IDLE.
REQ-025 Arithmetic SHALL be signed two's complement; products 2*DATA_W wide; dot accumulator 2*DATA_W wide with wrap; results truncated to low DATA_W bits.
REQ-026 start SHALL be ignored outside IDLE; inputs changing after latch SHALL have no effect.
REQ-027 addr1/addr2 SHALL hold their last value when not fetching; out_valid SHALL be 0 outside EMIT.

Reset
REQ-028 Rst low SHALL, at any time including mid-operation, force IDLE and zero addr1, addr2, out_valid, out_data, out_col, out_idx, busy, done, dot, counters and buffers.
REQ-029 After Rst release, no fetch SHALL occur until a new start.

Structure
REQ-030 Package hht_pkg SHALL hold the state enum and default parameter constants (DATA_W, ADDR_W, VLEN, SHIFT).
REQ-031 Sub-module hht_mac SHALL implement the signed multiply-accumulate with clear and enable, instantiated once.
REQ-032 Target size SHALL be 120-400 lines of RTL.

Verification
REQ-033 VLEN=4, SHIFT=1, v=[1,0,0,0], one column [4,2,3,1], out_ready=1 -> outputs 2,2,3,1, idx 0..3, then done pulse; LOAD_V and LOAD_COL 4 cycles each.
REQ-034 num_cols=0, start -> done one cycle after start, addr1/addr2 unchanged, out_valid never high.
REQ-035 Two columns, out_ready toggled 1,0,0,1 per cycle -> each output held stable while stalled; exactly 8 beats, column 1 read from col_base+4..7.
REQ-036 v=[-1,2,0,0], column [3,-5,0,0], SHIFT=0 -> dot=-13; outputs 3-13=-10, -5+26=21, 0, 0.
REQ-037 Rst pulsed low mid-EMIT -> all outputs 0 immediately, IDLE; new start runs a clean full sequence.
REQ-038 start re-asserted during LOAD_COL with different v_base -> ignored; results match the original request.
